// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP state machine, 4-bit instruction register,
// instruction decode and TDO mux between the IR shift path and the DR block.
package jtag_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR,
    SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
    UPDATE_DR, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR,
    EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_ctrl_fsm_t;
  typedef enum logic [2:0] {
    SAMPLE_PRELOAD, IDCODE, ADDR_AXI_REG, DATA_W_AXI_REG,
    DATA_R_AXI_REG, MGMT_AXI_REG, IC_RESET, BYPASS
  } ir_decoding_t;
endpackage

module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic                trstn,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output tap_ctrl_fsm_t       tap_state,
  output ir_decoding_t        ir_dec,
  output logic [IR_WIDTH-1:0] ir_value
);
  if (IR_WIDTH != 4) begin : g_width_check
    $error("jtag_tap_ctrl: IR_WIDTH must be 4");
  end
  logic [IR_WIDTH-1:0] r_ir_sr, r_ir_ff, r_ir_sr_n;
  tap_ctrl_fsm_t r_state_n;
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      tap_state <= TEST_LOGIC_RESET;
      r_ir_ff   <= IR_WIDTH'(4'h3);
      r_ir_sr   <= '0;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET: begin
          tap_state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
          r_ir_ff   <= IR_WIDTH'(4'h3);
          r_ir_sr   <= '0;
        end
        RUN_TEST_IDLE, UPDATE_DR: tap_state <= tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
        SELECT_DR_SCAN:           tap_state <= tms ? SELECT_IR_SCAN : CAPTURE_DR;
        SELECT_IR_SCAN:           tap_state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_DR, SHIFT_DR:     tap_state <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:                 tap_state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:                 tap_state <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:                 tap_state <= tms ? UPDATE_DR : SHIFT_DR;
        CAPTURE_IR: begin
          tap_state <= tms ? EXIT1_IR : SHIFT_IR;
          r_ir_sr   <= IR_WIDTH'(4'b0101);
        end
        SHIFT_IR: begin
          tap_state <= tms ? EXIT1_IR : SHIFT_IR;
          r_ir_sr   <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
        end
        EXIT1_IR:                 tap_state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:                 tap_state <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:                 tap_state <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR: begin
          tap_state <= tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
          r_ir_ff   <= r_ir_sr;
        end
      endcase
    end
  end
  // Falling-edge copies keep TDO stable across the whole rising edge that samples it.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      r_state_n <= TEST_LOGIC_RESET;
      r_ir_sr_n <= '0;
    end else begin
      r_state_n <= tap_state;
      r_ir_sr_n <= r_ir_sr;
    end
  end
  always_comb begin
    case (r_ir_ff)
      4'h1:    ir_dec = SAMPLE_PRELOAD;
      4'h3:    ir_dec = IDCODE;
      4'h4:    ir_dec = ADDR_AXI_REG;
      4'h5:    ir_dec = DATA_W_AXI_REG;
      4'h6:    ir_dec = DATA_R_AXI_REG;
      4'h7:    ir_dec = MGMT_AXI_REG;
      4'hC:    ir_dec = IC_RESET;
      default: ir_dec = BYPASS;
    endcase
  end
  assign ir_value = r_ir_ff;
  assign tdo_en   = (r_state_n == SHIFT_IR) || (r_state_n == SHIFT_DR);
  assign tdo      = (r_state_n == SHIFT_IR) ? r_ir_sr_n[0] : (r_state_n == SHIFT_DR) && dr_tdo;
endmodule
